vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed XGA hsync/vsync controller pair.
- Generates pixel/line counters, sync pulses, active-video and frame/line markers from one set of timing parameters, so the same block serves any VGA/XGA/SVGA mode.
- Adds a pixel-clock enable, run/stop control that only halts on a frame boundary, and a configurable sync-delay pipeline. The delay keeps sync aligned with a downstream pattern generator of known latency.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- SYNC_DLY, 0, pix_en stages of delay on hsync/vsync/video_on (0..7)
- X_W, 11, pixel_x width; elaboration error if 2**X_W < H_TOTAL
- Y_W, 10, pixel_y width; elaboration error if 2**Y_W < V_TOTAL

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- pix_en  input  1  pixel tick; counters/outputs advance only on clk edges with pix_en=1
- run  input  1  1 = generate frames; 0 = stop at end of current frame
- pixel_x  output  X_W  current horizontal count
- pixel_y  output  Y_W  current vertical count
- hsync  output  1  horizontal sync, delayed SYNC_DLY ticks
- vsync  output  1  vertical sync, delayed SYNC_DLY ticks
- video_on  output  1  active region, delayed SYNC_DLY ticks
- line_start  output  1  one-clk pulse when pixel x=0 is emitted
- frame_start  output  1  one-clk pulse when pixel (0,0) is emitted
- busy  output  1  state != IDLE

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters h_cnt and v_cnt are internal.
- Reset (asynchronous, immediate at any point including mid-frame):
  - state=IDLE, counters 0, pixel_x=0, pixel_y=0, video_on=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - line_start=0, frame_start=0, busy=0.
  - Delay pipeline filled with the inactive values.
- States:
  - IDLE: counters held at 0. Goes to RUN on the clk edge where run=1.
  - RUN: generates frames. Goes to STOP when run=0.
  - STOP: keeps generating. Goes back to RUN if run=1 again, with no glitch and no counter reset. Goes to IDLE on the tick that emits pixel (H_TOTAL-1, V_TOTAL-1).
- Each pix_en tick in RUN or STOP:
  - Output registers load from the current (h_cnt, v_cnt), then the counters advance. Latency is one clk from counter value to output.
  - h_cnt wraps H_TOTAL-1 → 0 and increments v_cnt; v_cnt wraps V_TOTAL-1 → 0.
  - The first tick after IDLE emits (0,0) with frame_start=1.
- Decode, before delay:
  - video_on = (h<H_ACTIVE) && (v<V_ACTIVE).
  - hsync active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC; it changes only at h=0.
- pixel_x/pixel_y report counts in blanking as well; they are never delayed.
- hsync/vsync/video_on pass through SYNC_DLY registers that shift only on pix_en. With SYNC_DLY=0 they are aligned with pixel_x/pixel_y.
- line_start/frame_start are high for exactly one clk: the clk after the emitting pix_en edge. They are not delayed.
- Without pix_en, all outputs hold. pix_en held at 1 gives one pixel per clk.
- In IDLE, the first pix_en tick loads outputs with their reset values. Until then the final pixel's values hold.
- run toggling while in IDLE with pix_en=0: the state still moves to RUN, but nothing is emitted until a pix_en tick.

Test Plan:
- Common setup for all scenarios unless stated: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), POL=0, SYNC_DLY=0.
- Reset then idle: reset=0 → hsync=vsync=1, video_on=0, busy=0. Release reset with run=0 → outputs unchanged after 50 clks.
- Continuous run (run=1, pix_en=1):
  - First output is (0,0) with frame_start and line_start pulses.
  - hsync=0 exactly for x=10..12; video_on=1 for x<8 and y<4.
  - x wraps 15→0 with y+1; vsync=0 for y=5..6.
  - frame_start repeats every 128 clks.
- Sparse enable, pix_en 1-in-4: pixel_x increments every 4 clks; line_start stays one clk wide; frame period is 512 clks.
- Stop and resume:
  - Drop run at (3,2) → continues to (15,7), then busy=0 and outputs inactive, counter frozen at 0.
  - Drop run, then re-raise it before the frame ends → frame_start continues every 128 clks.
- Sync delay (SYNC_DLY=2): hsync falls two ticks after pixel_x=10 is emitted; video_on falls at pixel_x=10.
- Polarity and reset (HSYNC_POL=1): hsync=1 during x=10..12. Asserting reset at (12,1) → hsync=0 and pixel_x=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator
// Counters, sync/blank decode, pixel-enable pacing, frame-boundary stop and sync delay.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int SYNC_DLY  = 0,
  parameter int X_W       = 11,
  parameter int Y_W       = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_en,
  input  logic           run,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic           line_start,
  output logic           frame_start,
  output logic           busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);

  localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
  localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
  localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  if (2**X_W < H_TOTAL) begin : g_xw_check
    $error("vga_timing_gen: X_W too narrow for H_TOTAL");
  end
  if (2**Y_W < V_TOTAL) begin : g_yw_check
    $error("vga_timing_gen: Y_W too narrow for V_TOTAL");
  end
  if (SYNC_DLY < 0 || SYNC_DLY > 7) begin : g_dly_check
    $error("vga_timing_gen: SYNC_DLY must be 0..7");
  end

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic [31:0]    h_ext;
  logic [31:0]    v_ext;
  logic           at_last;
  logic           hs_act;
  logic           vs_act;
  logic           vid_act;

  // Each stage holds active-high {hsync, vsync, video_on}; stage 0 is aligned with pixel_x/pixel_y.
  logic [2:0]     pipe [0:SYNC_DLY];

  assign h_ext   = 32'(h_cnt);
  assign v_ext   = 32'(v_cnt);
  assign at_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign hs_act  = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_act  = (v_ext >= VS_START) && (v_ext < VS_END);
  assign vid_act = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);

  // Stopping only takes effect on the tick that emits the last pixel of the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (run) state_nxt = ST_RUN;
      ST_RUN:  if (!run) state_nxt = (pix_en && at_last) ? ST_IDLE : ST_STOP;
      ST_STOP: begin
        if (run)                    state_nxt = ST_RUN;
        else if (pix_en && at_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      for (int i = 0; i <= SYNC_DLY; i++) pipe[i] <= 3'b000;
    end else begin
      state       <= state_nxt;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        if (state == ST_RUN || state == ST_STOP) begin
          pixel_x     <= h_cnt;
          pixel_y     <= v_cnt;
          line_start  <= (h_cnt == '0);
          frame_start <= (h_cnt == '0) && (v_cnt == '0);
          pipe[0]     <= {hs_act, vs_act, vid_act};
          for (int i = 1; i <= SYNC_DLY; i++) pipe[i] <= pipe[i-1];
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end else begin
          // First idle tick returns every output to its reset value.
          h_cnt   <= '0;
          v_cnt   <= '0;
          pixel_x <= '0;
          pixel_y <= '0;
          for (int i = 0; i <= SYNC_DLY; i++) pipe[i] <= 3'b000;
        end
      end
    end
  end

  assign hsync    = (HSYNC_POL != 0) ? pipe[SYNC_DLY][2] : ~pipe[SYNC_DLY][2];
  assign vsync    = (VSYNC_POL != 0) ? pipe[SYNC_DLY][1] : ~pipe[SYNC_DLY][1];
  assign video_on = pipe[SYNC_DLY][0];
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen
// Three instances on shared stimulus: baseline, SYNC_DLY=2, HSYNC_POL=1.
module tb_vga_timing_gen;

  logic clk;
  logic reset;
  logic pix_en;
  logic run;

  logic [3:0] x0, xd, xp;
  logic [2:0] y0, yd, yp;
  logic hs0, vs0, vo0, ls0, fs0, bz0;
  logic hsd, vsd, vod, lsd, fsd, bzd;
  logic hsp, vsp, vop, lsp, fsp, bzp;

  int n_checks = 0;
  int n_errors = 0;
  int sparse   = 0;
  int phase    = 0;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(0), .VSYNC_POL(0), .SYNC_DLY(0), .X_W(4), .Y_W(3)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .run(run),
    .pixel_x(x0), .pixel_y(y0), .hsync(hs0), .vsync(vs0), .video_on(vo0),
    .line_start(ls0), .frame_start(fs0), .busy(bz0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(0), .VSYNC_POL(0), .SYNC_DLY(2), .X_W(4), .Y_W(3)
  ) dut_dly (
    .clk(clk), .reset(reset), .pix_en(pix_en), .run(run),
    .pixel_x(xd), .pixel_y(yd), .hsync(hsd), .vsync(vsd), .video_on(vod),
    .line_start(lsd), .frame_start(fsd), .busy(bzd)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(0), .SYNC_DLY(0), .X_W(4), .Y_W(3)
  ) dut_pol (
    .clk(clk), .reset(reset), .pix_en(pix_en), .run(run),
    .pixel_x(xp), .pixel_y(yp), .hsync(hsp), .vsync(vsp), .video_on(vop),
    .line_start(lsp), .frame_start(fsp), .busy(bzp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    if (sparse != 0) begin
      pix_en = (phase == 0);
      phase  = (phase + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  int found, cnt, wide, prev_ls, any_bad, ex, ey, kd, exd, eyd;

  initial begin
    reset = 1'b1; run = 1'b0; pix_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_hsync", int'(hs0), 1);
    check("rst_vsync", int'(vs0), 1);
    check("rst_video", int'(vo0), 0);
    check("rst_busy", int'(bz0), 0);
    check("rst_x", int'(x0), 0);
    check("rst_y", int'(y0), 0);
    check("rst_ls", int'(ls0), 0);
    check("rst_fs", int'(fs0), 0);
    check("rst_hsync_pol", int'(hsp), 0);

    @(posedge clk); #1;
    reset = 1'b1; pix_en = 1'b1;
    repeat (50) step();
    check("idle_hsync", int'(hs0), 1);
    check("idle_vsync", int'(vs0), 1);
    check("idle_video", int'(vo0), 0);
    check("idle_busy", int'(bz0), 0);
    check("idle_x", int'(x0), 0);
    check("idle_fs", int'(fs0), 0);

    // Continuous run: two full frames checked pixel by pixel.
    run = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fs0) begin found = 1; break; end
    end
    check("first_fs_seen", found, 1);
    for (int k = 0; k < 256; k++) begin
      ex  = k % 16;
      ey  = (k / 16) % 8;
      kd  = (k + 254) % 128;
      exd = kd % 16;
      eyd = kd / 16;
      check("run_x", int'(x0), ex);
      check("run_y", int'(y0), ey);
      check("run_hsync", int'(hs0), (ex >= 10 && ex <= 12) ? 0 : 1);
      check("run_vsync", int'(vs0), (ey >= 5 && ey <= 6) ? 0 : 1);
      check("run_video", int'(vo0), (ex < 8 && ey < 4) ? 1 : 0);
      check("run_ls", int'(ls0), (ex == 0) ? 1 : 0);
      check("run_fs", int'(fs0), (k % 128 == 0) ? 1 : 0);
      check("dly_hsync", int'(hsd), (exd >= 10 && exd <= 12) ? 0 : 1);
      check("dly_video", int'(vod), (exd < 8 && eyd < 4) ? 1 : 0);
      check("dly_x_undelayed", int'(xd), ex);
      check("pol_hsync", int'(hsp), (ex >= 10 && ex <= 12) ? 1 : 0);
      step();
    end
    check("fs_period_128", int'(fs0), 1);

    // Sparse enable, one tick in four.
    sparse = 1; phase = 0;
    found = 0;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (fs0) begin found = 1; break; end
    end
    check("sparse_fs_seen", found, 1);
    found = 0; cnt = 0; wide = 0; prev_ls = int'(ls0);
    for (int c = 1; c <= 1200; c++) begin
      step();
      if (c == 3) check("sparse_x_hold", int'(x0), 0);
      if (c == 4) check("sparse_x_inc", int'(x0), 1);
      if (c == 8) check("sparse_x_inc2", int'(x0), 2);
      if (ls0 && prev_ls != 0) wide = 1;
      prev_ls = int'(ls0);
      if (fs0) begin found = 1; cnt = c; break; end
    end
    check("sparse_fs_found", found, 1);
    check("sparse_frame_period", cnt, 512);
    check("sparse_ls_width", wide, 0);
    sparse = 0; pix_en = 1'b1;

    // Stop at end of frame.
    found = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (x0 == 4'd3 && y0 == 3'd2) begin found = 1; break; end
    end
    check("stop_reach_3_2", found, 1);
    run = 1'b0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!bz0) begin found = 1; break; end
    end
    check("stop_busy_drop", found, 1);
    check("stop_last_x", int'(x0), 15);
    check("stop_last_y", int'(y0), 7);
    step();
    check("stop_idle_x", int'(x0), 0);
    check("stop_idle_y", int'(y0), 0);
    check("stop_idle_hsync", int'(hs0), 1);
    check("stop_idle_vsync", int'(vs0), 1);
    check("stop_idle_video", int'(vo0), 0);
    any_bad = 0;
    repeat (20) begin
      step();
      if (fs0 || bz0 || x0 != 4'd0) any_bad = 1;
    end
    check("stop_frozen", any_bad, 0);

    // run raised in IDLE without pixel ticks.
    pix_en = 1'b0; run = 1'b1;
    step();
    check("idle_run_busy", int'(bz0), 1);
    any_bad = 0;
    repeat (3) begin
      step();
      if (fs0 || x0 != 4'd0) any_bad = 1;
    end
    check("idle_run_no_emit", any_bad, 0);
    pix_en = 1'b1;

    // Drop and re-raise run mid-frame.
    found = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fs0) begin found = 1; break; end
    end
    check("resume_fs_seen", found, 1);
    check("resume_first_x", int'(x0), 0);
    found = 0; cnt = 0; any_bad = 0;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (c == 60) run = 1'b0;
      if (c == 70) run = 1'b1;
      if (!bz0) any_bad = 1;
      if (fs0) begin found = 1; cnt = c; break; end
    end
    check("resume_fs_found", found, 1);
    check("resume_period", cnt, 128);
    check("resume_busy_held", any_bad, 0);

    // Async reset mid-line while hsync is active.
    found = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (xp == 4'd12 && yp == 3'd1) begin found = 1; break; end
    end
    check("pol_reach_12_1", found, 1);
    check("pol_hsync_active", int'(hsp), 1);
    check("base_hsync_active", int'(hs0), 0);
    #2 reset = 1'b0;
    #1;
    check("async_pol_hsync", int'(hsp), 0);
    check("async_pol_x", int'(xp), 0);
    check("async_x", int'(x0), 0);
    check("async_hsync", int'(hs0), 1);
    check("async_busy", int'(bz0), 0);
    check("async_dly_hsync", int'(hsd), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
